// File: rtl/mem_stage_ctrl_if.sv
// Bus bundle between the MEM-stage controller, the pipeline and the data SRAM.
//   Pipeline side: mem_read, mem_write, addr, wr_data (requests),
//                  rd_data, ready, freeze (responses).
//   SRAM side:     sram_en, sram_we, sram_addr, sram_wdata (strobes/payload),
//                  sram_rdata (read return).
// Modports: slave = controller view, master = environment (pipeline + SRAM) view.
interface mem_stage_ctrl_if #(
  parameter int unsigned AW = 16
);
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   addr;
  logic [31:0]   wr_data;
  logic [31:0]   rd_data;
  logic          ready;
  logic          freeze;
  logic          sram_en;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  modport slave (
    input  mem_read, mem_write, addr, wr_data, sram_rdata,
    output rd_data, ready, freeze, sram_en, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output mem_read, mem_write, addr, wr_data, sram_rdata,
    input  rd_data, ready, freeze, sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory sequencer. Drives a fixed-latency synchronous SRAM and
// stalls the whole pipeline (freeze) while an access is in flight; the load
// result is held on rd_data for the MEM/WB register.
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : mem_read/mem_write/addr/wr_data in, rd_data/ready/freeze out,
//                     sram_en/sram_we/sram_addr/sram_wdata out, sram_rdata in
// Parameters: BASE_ADDR (byte address of SRAM word 0), AW (SRAM word-address
// width), SRAM_WAIT (cycles per SRAM access, 1..15).
// Optional feature: define MEM_CTRL_WRBUF_EN for a single-entry posted write
// buffer (stores complete without stalling the pipeline).
// freeze is combinational; every other output is registered.
module mem_stage_ctrl #(
  parameter int unsigned BASE_ADDR = 1024,
  parameter int unsigned AW        = 16,
  parameter int unsigned SRAM_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  mem_stage_ctrl_if.slave bus
);

  localparam int unsigned   CW   = 4;
  localparam logic [CW-1:0] LAST = CW'(SRAM_WAIT - 1);
  localparam logic [31:0]   BASE = 32'(BASE_ADDR);

`ifdef MEM_CTRL_WRBUF_EN
  localparam bit WRBUF_EN = 1'b1;
`else
  localparam bit WRBUF_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic           posted, posted_nx;
  logic           req;
  logic           freeze_c;

  logic [31:0]    rd_data, rd_nx;
  logic           ready, ready_nx;
  logic           sram_en, en_nx;
  logic           sram_we, we_nx;
  logic [AW-1:0]  sram_addr, addr_nx;
  logic [31:0]    sram_wdata, wdata_nx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state, combinational freeze and next values of registered outputs
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    posted_nx = posted;
    rd_nx     = rd_data;
    ready_nx  = 1'b0;
    en_nx     = sram_en;
    we_nx     = sram_we;
    addr_nx   = sram_addr;
    wdata_nx  = sram_wdata;
    freeze_c  = 1'b0;
    req       = bus.mem_read | bus.mem_write;

    unique case (state)
      IDLE: begin
        if (req) begin
          state_nx  = ACCESS;
          cnt_nx    = '0;
          en_nx     = 1'b1;
          // A simultaneous read and write is serviced as a read only.
          we_nx     = bus.mem_write & ~bus.mem_read;
          // Word index relative to BASE_ADDR; wraps modulo the SRAM size.
          addr_nx   = AW'((bus.addr - BASE) >> 2);
          wdata_nx  = bus.wr_data;
          posted_nx = WRBUF_EN & we_nx;
          freeze_c  = ~posted_nx;
          // A one-cycle posted write finishes in its first access cycle.
          if (posted_nx && LAST == '0) ready_nx = 1'b1;
        end
      end

      ACCESS: begin
        // A posted write only stalls a younger request waiting behind it.
        freeze_c = posted ? req : 1'b1;
        cnt_nx   = cnt + CW'(1);
        if (cnt == LAST) begin
          en_nx = 1'b0;
          we_nx = 1'b0;
          if (!sram_we) rd_nx = bus.sram_rdata;
          if (posted) begin
            state_nx  = IDLE;
            posted_nx = 1'b0;
          end else begin
            state_nx = DONE;
            ready_nx = 1'b1;
          end
        end else if (posted && (cnt + CW'(1)) == LAST) begin
          ready_nx = 1'b1;
        end
      end

      DONE: begin
        // The completed request is still presented this cycle; ignore it.
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    if (rst) freeze_c = 1'b0;
  end

  // Counter, latched request and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      posted     <= 1'b0;
      rd_data    <= '0;
      ready      <= 1'b0;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      cnt        <= cnt_nx;
      posted     <= posted_nx;
      rd_data    <= rd_nx;
      ready      <= ready_nx;
      sram_en    <= en_nx;
      sram_we    <= we_nx;
      sram_addr  <= addr_nx;
      sram_wdata <= wdata_nx;
    end
  end

  assign bus.rd_data    = rd_data;
  assign bus.ready      = ready;
  assign bus.freeze     = freeze_c;
  assign bus.sram_en    = sram_en;
  assign bus.sram_we    = sram_we;
  assign bus.sram_addr  = sram_addr;
  assign bus.sram_wdata = sram_wdata;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: behavioural SRAM, transaction-level
// reference memory and randomized load/store traffic.
module tb_mem_stage_ctrl;

  localparam int unsigned BASE      = 1024;
  localparam int unsigned AW        = 16;
  localparam int unsigned SRAM_WAIT = 4;
`ifdef MEM_CTRL_WRBUF_EN
  localparam bit WRBUF = 1'b1;
`else
  localparam bit WRBUF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_ctrl_if #(.AW(AW)) bus ();

  mem_stage_ctrl #(
    .BASE_ADDR (BASE),
    .AW        (AW),
    .SRAM_WAIT (SRAM_WAIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural SRAM: write commits on the last cycle of a continuous strobe.
  bit [31:0] sram [65536];
  int        en_cnt = 0;
  always_comb bus.sram_rdata = sram[bus.sram_addr];
  always @(posedge clk) begin
    if (bus.sram_en === 1'b1) begin
      if (en_cnt == SRAM_WAIT - 1 && bus.sram_we === 1'b1)
        sram[bus.sram_addr] <= bus.sram_wdata;
      en_cnt <= en_cnt + 1;
    end else begin
      en_cnt <= 0;
    end
  end

  // Reference model state
  bit [31:0] ref_mem [65536];
  logic [31:0] exp_rd = '0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [31:0] a);
    return 16'(((a - BASE) / 4) % 65536);
  endfunction

  // One pipeline request, called at a negedge; returns at a negedge with strobes low.
  task automatic run_req(input string tag, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
    int   frz = 0, en_c = 0, we_c = 0;
    bit   seen = 0, bus_ok = 1;
    bit   is_wr = wr && !rd;
    bit   posted = WRBUF && is_wr;
    logic [15:0] w = word_of(a);
    bus.mem_read = rd; bus.mem_write = wr; bus.addr = a; bus.wr_data = d;
    for (int c = 0; c < 40 && !seen; c++) begin
      #1;
      if (bus.freeze === 1'b1) frz++;
      if (bus.sram_en === 1'b1) begin
        en_c++;
        if (bus.sram_we === 1'b1) we_c++;
        if (bus.sram_addr !== w || (is_wr && bus.sram_wdata !== d)) bus_ok = 0;
      end
      if (bus.ready === 1'b1) begin
        seen = 1;
        check({tag, "_frz_at_ready"}, 32'(bus.freeze), 32'(0));
      end else begin
        @(negedge clk);
        if (c == 0) begin
          if (posted) begin
            bus.mem_read = 1'b0; bus.mem_write = 1'b0;
          end
          // Latched fields must not follow later input changes.
          bus.addr = $urandom; bus.wr_data = $urandom;
        end
      end
    end
    if (is_wr) ref_mem[w] = d;
    else       exp_rd = ref_mem[w];
    check({tag, "_ready_seen"}, 32'(seen), 32'(1));
    check({tag, "_frz_cycles"}, 32'(frz), posted ? 32'(0) : 32'(SRAM_WAIT + 1));
    check({tag, "_en_cycles"}, 32'(en_c), 32'(SRAM_WAIT));
    check({tag, "_we_cycles"}, 32'(we_c), is_wr ? 32'(SRAM_WAIT) : 32'(0));
    check({tag, "_bus_fields"}, 32'(bus_ok), 32'(1));
    check({tag, "_rd_data"}, bus.rd_data, exp_rd);
    @(negedge clk);
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    check({tag, "_sram_word"}, sram[w], ref_mem[w]);
  endtask

  initial begin
    rst = 1'b1;
    bus.mem_read = 1'b1; bus.mem_write = 1'b0;
    bus.addr = 32'd1036; bus.wr_data = '0;

    // Reset with a load held on the inputs
    repeat (2) begin
      @(negedge clk); #1;
      check("rst_freeze", 32'(bus.freeze), 32'(0));
      check("rst_sram_en", 32'(bus.sram_en), 32'(0));
      check("rst_rd_data", bus.rd_data, 32'(0));
      check("rst_ready", 32'(bus.ready), 32'(0));
    end
    @(negedge clk);
    rst = 1'b0; bus.mem_read = 1'b0;
    @(negedge clk);

    // Word 3 preload, then the basic load
    run_req("st3", 1'b0, 1'b1, 32'd1036, 32'hDEADBEEF);
    run_req("ld3", 1'b1, 1'b0, 32'd1036, 32'h0);
    check("ld3_value", bus.rd_data, 32'hDEADBEEF);

    // Store then load on word 0, back to back
    run_req("st0", 1'b0, 1'b1, 32'd1024, 32'h12345678);
    run_req("ld0", 1'b1, 1'b0, 32'd1024, 32'h0);
    check("ld0_value", bus.rd_data, 32'h12345678);

    // Both strobes: read only, word 1 untouched
    run_req("both", 1'b1, 1'b1, 32'd1028, 32'hA5A5A5A5);
    check("both_word1", sram[1], 32'h0);

    // Reset during the second access cycle of a store
    bus.mem_write = 1'b1; bus.addr = 32'd1032; bus.wr_data = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.mem_write = 1'b0;
    #1;
    check("abort_sram_en", 32'(bus.sram_en), 32'(0));
    check("abort_ready", 32'(bus.ready), 32'(0));
    check("abort_freeze", 32'(bus.freeze), 32'(0));
    @(negedge clk); #1;
    check("abort_idle_en", 32'(bus.sram_en), 32'(0));
    check("abort_word2", sram[2], ref_mem[2]);
    @(negedge clk);
    exp_rd = '0;
    run_req("ld_after_rst", 1'b1, 1'b0, 32'd1036, 32'h0);
    check("ld_after_rst_value", bus.rd_data, 32'hDEADBEEF);

`ifdef MEM_CTRL_WRBUF_EN
    // Posted store followed immediately by a load of the same word
    begin
      int frz = 0;
      bit seen = 0;
      bus.mem_write = 1'b1; bus.mem_read = 1'b0;
      bus.addr = 32'd1064; bus.wr_data = 32'h0BADF00D;
      #1;
      check("wb_store_frz", 32'(bus.freeze), 32'(0));
      @(negedge clk);
      bus.mem_write = 1'b0; bus.mem_read = 1'b1;
      for (int c = 0; c < 40 && !seen; c++) begin
        #1;
        if (bus.ready === 1'b1 && bus.freeze === 1'b0) seen = 1;
        else begin
          if (bus.freeze === 1'b1) frz++;
          @(negedge clk);
        end
      end
      ref_mem[10] = 32'h0BADF00D;
      exp_rd = 32'h0BADF00D;
      check("wb_seen", 32'(seen), 32'(1));
      check("wb_frz_cycles", 32'(frz), 32'(2 * SRAM_WAIT + 1));
      check("wb_rd_data", bus.rd_data, 32'h0BADF00D);
      @(negedge clk);
      bus.mem_read = 1'b0;
    end
`endif

    // Randomized traffic, including addresses below BASE (wrapping word index)
    for (int i = 0; i < 40; i++) begin
      bit rd, wr;
      logic [31:0] a;
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        #1;
        check("idle_freeze", 32'(bus.freeze), 32'(0));
        @(negedge clk);
      end
      rd = 1'($urandom_range(0, 1));
      wr = !rd || ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) a = BASE - 4 * $urandom_range(1, 8);
      else a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      run_req("rnd", rd, wr, a, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
